switch_event_logger: RTL and testbench
======================================

// Module: switch_event_logger
// PURPOSE
//  Fabric-side producer for the on-chip memory second port (s2) of the nios_setup system.
//  Synchronises and debounces the 8 board switches and timestamps each debounced change.
//  Writes each change as one 32-bit record into a ring buffer in on-chip RAM via s2.
//  The Nios CPU consumes records over s1 and advances a tail word in RAM.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000   stable cycles required before a switch change is accepted (1 ms @ 50 MHz)
//  TS_PRESCALE      50      clk cycles per timestamp tick (1 us @ 50 MHz)
//  HDR_ADDR         12'hF00 word address of head word; tail word is HDR_ADDR+1
//  RING_BASE        12'hF02 word address of ring slot 0
//  RING_DEPTH       64      ring slots; power of two, >=4; RING_BASE+RING_DEPTH<=4096; header outside ring
// PORTS
//  clk_clk          in   1   system clock, same domain as on-chip memory s2
//  reset_reset_n    in   1   asynchronous active-low reset
//  switch_in        in   8   raw switch inputs (asynchronous)
//  s2_address       out  12  word address to onchip_memory_s2_address
//  s2_chipselect    out  1   access strobe
//  s2_clken         out  1   RAM clock enable; equals s2_chipselect
//  s2_write         out  1   1=write, 0=read
//  s2_writedata     out  32  write data
//  s2_byteenable    out  4   always 4'hF while s2_chipselect=1, else 4'h0
//  s2_readdata      in   32  read data, valid exactly 1 cycle after read strobe
//  debounced_sw     out  8   current debounced switch value
//  drop_count       out  8   saturating count of lost events (ring full or pending overwritten)
//  event_pulse      out  1   one-cycle pulse when a record is committed (head written)
// BEHAVIOUR
//  Reset: all outputs 0; head=0; timestamp=0; debounced_sw=0; FSM in INIT.
//  Input: 2-FF synchroniser per bit. Debounce on the whole 8-bit vector: counter restarts
//   when synced value changes; when it reaches DEBOUNCE_CYCLES-1 with value != debounced_sw,
//   debounced_sw updates next cycle and an event {new value, timestamp[23:0]} is latched pending.
//  Timestamp: 24-bit, +1 every TS_PRESCALE cycles, wraps 24'hFFFFFF->0 silently.
//  Record: [31:24]=debounced switch value, [23:0]=timestamp at acceptance.
//  Pending holder: single entry. New event while one is pending and not yet in WR_REC:
//   overwrite (latest wins), drop_count+1. drop_count saturates at 8'hFF.
//  FSM (one s2 access per cycle, strobes registered):
//   INIT     : write 0 to HDR_ADDR -> IDLE.
//   IDLE     : strobes low; pending -> RD_TAIL.
//   RD_TAIL  : read HDR_ADDR+1 -> WAIT_TAIL.
//   WAIT_TAIL: capture tail = s2_readdata[log2(RING_DEPTH)-1:0] (upper bits ignored);
//              if ((head+1) mod RING_DEPTH)==tail: full, drop pending, drop_count+1 -> IDLE;
//              else -> WR_REC.
//   WR_REC   : write record to RING_BASE+head; clear pending -> WR_HEAD.
//   WR_HEAD  : write zero-extended (head+1) mod RING_DEPTH to HDR_ADDR; head advances;
//              event_pulse=1 this cycle -> IDLE.
//  Latency: debounce accept to head write = 5 cycles minimum (pending, RD_TAIL, WAIT, WR_REC, WR_HEAD).
//  Capacity: RING_DEPTH-1 records (one slot kept empty to tell full from empty).
//  Head wrap: RING_DEPTH-1 -> 0. Tail is re-read for every record; never cached.
//  Event accepted in the same cycle as WR_REC clears pending: new event becomes pending, no drop.
//  Reset mid-operation: immediate abort, strobes low, re-enters INIT (header rewritten to 0).
// STRUCTURE
//  Package switch_event_logger_pkg: FSM state enum (INIT, IDLE, RD_TAIL, WAIT_TAIL, WR_REC,
//   WR_HEAD), record field offsets, TS_WIDTH=24.
//  Sub-module sw_debounce (synchroniser + stability counter, outputs value and accept pulse);
//   FSM, timestamp, ring pointer in top level.
// TESTING (bench models s2 as 4096x32 RAM, 1-cycle read latency)
//  Reset release -> one write HDR_ADDR=0, then strobes idle; all outputs 0.
//  switch_in 0->8'h05, stable DEBOUNCE_CYCLES -> RAM[RING_BASE]={8'h05,ts}, RAM[HDR_ADDR]=1, one event_pulse.
//  Bounce: toggle bit0 every 10 cycles for 1000 cycles, then settle 1 -> exactly one record 8'h01.
//  Tail held 0, 64 distinct changes -> 63 records, head=63, drop_count=1; set tail=10 -> next change lands slot 63, head wraps to 0.
//  Two changes accepted while FSM stalled in RD_TAIL/WAIT_TAIL -> only latest recorded, drop_count+1.
//  Assert reset_reset_n low during WR_REC -> no write that cycle; after release INIT rewrites head=0.

Source files
------------

// File: rtl/switch_event_logger_pkg.sv
// Shared types and constants for the switch event logger.
package switch_event_logger_pkg;

  localparam int TS_WIDTH  = 24;
  localparam int S2_ADDR_W = 12;
  localparam int S2_DATA_W = 32;

  // Record layout: [31:24] debounced switches, [23:0] timestamp.
  localparam int REC_SW_LSB = 24;
  localparam int REC_SW_W   = 8;
  localparam int REC_TS_LSB = 0;

  // FSM encoding.
  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t ST_INIT      = 3'd0;
  localparam fsm_state_t ST_IDLE      = 3'd1;
  localparam fsm_state_t ST_RD_TAIL   = 3'd2;
  localparam fsm_state_t ST_WAIT_TAIL = 3'd3;
  localparam fsm_state_t ST_WR_REC    = 3'd4;
  localparam fsm_state_t ST_WR_HEAD   = 3'd5;

  function automatic logic [S2_DATA_W-1:0] make_record(input logic [REC_SW_W-1:0] sw,
                                                       input logic [TS_WIDTH-1:0] ts);
    logic [S2_DATA_W-1:0] rec;
    rec = '0;
    rec[REC_SW_LSB +: REC_SW_W] = sw;
    rec[REC_TS_LSB +: TS_WIDTH] = ts;
    return rec;
  endfunction

endpackage

// File: rtl/switch_event_logger_if.sv
// On-chip memory second-port bus (s2) between the logger and the RAM.
// Handshake: chipselect is the only qualifier (valid); there is no ready --
// the RAM accepts every strobed access in the cycle it is presented, and for
// a read (write=0) readdata is valid exactly one cycle after the strobe.
// clken mirrors chipselect, byteenable is 4'hF while chipselect=1 else 4'h0.
interface switch_event_logger_if;
  import switch_event_logger_pkg::*;

  logic [S2_ADDR_W-1:0] address;
  logic                 chipselect;
  logic                 clken;
  logic                 write;
  logic [S2_DATA_W-1:0] writedata;
  logic [3:0]           byteenable;
  logic [S2_DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, clken, write, writedata, byteenable,
    input  readdata
  );

  modport slave (
    input  address, chipselect, clken, write, writedata, byteenable,
    output readdata
  );
endinterface

// File: rtl/switch_event_logger_sw_debounce.sv
// Two-flop synchroniser plus whole-vector stability counter for 8 switches.
// accept is a one-cycle pulse in the cycle a new stable value is taken;
// value follows one cycle later.
module sw_debounce
  import switch_event_logger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REC_SW_W-1:0] switch_in,
  output logic [REC_SW_W-1:0] value,
  output logic                accept,
  output logic [REC_SW_W-1:0] accept_value
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [REC_SW_W-1:0] sync1, sync2, sample;
  logic [CNT_W-1:0]    cnt;

  // Bring the asynchronous switch levels into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
    end
  end

  // Restart the stability count on any change; hold at CNT_MAX once stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
      cnt    <= '0;
    end else if (sync2 != sample) begin
      sample <= sync2;
      cnt    <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign accept       = (cnt == CNT_MAX) && (sample != value);
  assign accept_value = sample;

  // Commit the accepted value; accept drops the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else if (accept) value <= sample;
  end

endmodule

// File: rtl/switch_event_logger.sv
// Debounced switch change logger writing timestamped records into an
// on-chip RAM ring buffer through the s2 port. Head word at HDR_ADDR,
// tail word (owned by the CPU) at HDR_ADDR+1, slots from RING_BASE.
module switch_event_logger
  import switch_event_logger_pkg::*;
#(
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter int                   TS_PRESCALE     = 50,
  parameter logic [S2_ADDR_W-1:0] HDR_ADDR        = 12'hF00,
  parameter logic [S2_ADDR_W-1:0] RING_BASE       = 12'hF02,
  parameter int                   RING_DEPTH      = 64
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [REC_SW_W-1:0]   switch_in,
  switch_event_logger_if.master s2,
  output logic [REC_SW_W-1:0]   debounced_sw,
  output logic [7:0]            drop_count,
  output logic                  event_pulse,
  output fsm_state_t            fsm_state
);

  localparam int PTR_W = $clog2(RING_DEPTH);
  localparam int PRE_W = $clog2(TS_PRESCALE + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TS_PRESCALE - 1);

  fsm_state_t           state;
  logic [PTR_W-1:0]     head, head_next, tail_rd;
  logic                 full, accept, drop_inc, pend_valid;
  logic [REC_SW_W-1:0]  accept_value;
  logic [S2_DATA_W-1:0] new_rec, pend_rec;
  logic [TS_WIDTH-1:0]  ts;
  logic [PRE_W-1:0]     pre;
  logic                 cs_q, wr_q;
  logic [S2_ADDR_W-1:0] addr_q;
  logic [S2_DATA_W-1:0] wdata_q;
  logic                 readdata_unused;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk          (clk_clk),
    .rst_n        (reset_reset_n),
    .switch_in    (switch_in),
    .value        (debounced_sw),
    .accept       (accept),
    .accept_value (accept_value)
  );

  assign head_next = head + 1'b1;
  assign tail_rd   = s2.readdata[PTR_W-1:0];
  assign full      = (head_next == tail_rd);
  assign new_rec   = make_record(accept_value, ts);
  // The tail word only carries PTR_W meaningful bits.
  assign readdata_unused = ^s2.readdata[S2_DATA_W-1:PTR_W];

  // One lost event per cycle at most: an overwrite of a pending entry, or a
  // full ring (if both coincide, only the older entry is actually lost).
  assign drop_inc = (accept && pend_valid && state != ST_WR_REC) ||
                    (state == ST_WAIT_TAIL && full && pend_valid);

  assign s2.address    = addr_q;
  assign s2.chipselect = cs_q;
  assign s2.clken      = cs_q;
  assign s2.write      = wr_q;
  assign s2.writedata  = wdata_q;
  assign s2.byteenable = {4{cs_q}};
  assign fsm_state     = state;

  // Free-running timestamp: one tick every TS_PRESCALE clocks, wraps silently.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre <= '0;
      ts  <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      ts  <= ts + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Single-entry pending holder (latest wins) and saturating drop counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_valid <= 1'b0;
      pend_rec   <= '0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_rec   <= new_rec;
      end else if (state == ST_WR_REC || (state == ST_WAIT_TAIL && full)) begin
        pend_valid <= 1'b0;
      end
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

  // Ring-writer FSM. Bus registers are loaded on the transition into the
  // state that owns the access, so they are valid during that state; the
  // INIT header clear therefore appears on the bus in the first IDLE cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= ST_INIT;
      head        <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      event_pulse <= 1'b0;
    end else begin
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      event_pulse <= 1'b0;
      case (state)
        ST_INIT: begin
          cs_q   <= 1'b1;
          wr_q   <= 1'b1;
          addr_q <= HDR_ADDR;
          state  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (pend_valid) begin
            cs_q   <= 1'b1;
            addr_q <= HDR_ADDR + 12'd1;
            state  <= ST_RD_TAIL;
          end
        end
        ST_RD_TAIL: state <= ST_WAIT_TAIL;
        ST_WAIT_TAIL: begin
          if (full) begin
            state <= ST_IDLE;
          end else begin
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= RING_BASE + S2_ADDR_W'(head);
            // A same-cycle accept replaces the pending record.
            wdata_q <= accept ? new_rec : pend_rec;
            state   <= ST_WR_REC;
          end
        end
        ST_WR_REC: begin
          cs_q        <= 1'b1;
          wr_q        <= 1'b1;
          addr_q      <= HDR_ADDR;
          wdata_q     <= S2_DATA_W'(head_next);
          event_pulse <= 1'b1;
          state       <= ST_WR_HEAD;
        end
        ST_WR_HEAD: begin
          head  <= head_next;
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_event_logger.sv
// Directed + randomized bench for switch_event_logger with a 4096x32 RAM model.
module tb_switch_event_logger;
  import switch_event_logger_pkg::*;

  localparam int D     = 3;
  localparam int P     = 5;
  localparam int DEPTH = 64;
  localparam logic [11:0] HDR = 12'hF00;
  localparam logic [11:0] RB  = 12'hF02;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] switch_in = 8'h00;
  logic [7:0] debounced_sw, drop_count;
  logic       event_pulse;
  fsm_state_t fsm_state;

  switch_event_logger_if s2();

  switch_event_logger #(
    .DEBOUNCE_CYCLES(D), .TS_PRESCALE(P), .HDR_ADDR(HDR),
    .RING_BASE(RB), .RING_DEPTH(DEPTH)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .switch_in     (switch_in),
    .s2            (s2),
    .debounced_sw  (debounced_sw),
    .drop_count    (drop_count),
    .event_pulse   (event_pulse),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset-relative cycle counter ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // ---------------- RAM model + bus monitor ----------------
  logic [31:0] mem [0:4095];
  logic [31:0] rd_q = '0;
  assign s2.readdata = rd_q;

  logic [37:0] exp_q[$];
  logic [37:0] act_q[$];
  int hdr_writes = 0;
  int pulses = 0;
  int bus_bad = 0;

  always @(posedge clk) begin
    if (s2.chipselect && s2.write) begin
      mem[s2.address] <= s2.writedata;
      if (s2.address == HDR) hdr_writes++;
      if (s2.address >= RB && s2.address < RB + 12'(DEPTH))
        act_q.push_back({6'(s2.address - RB), s2.writedata});
    end
    if (s2.chipselect && !s2.write) rd_q <= mem[s2.address];
    if (event_pulse) pulses++;
    if (s2.clken !== s2.chipselect || s2.byteenable !== (s2.chipselect ? 4'hF : 4'h0))
      bus_bad++;
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int m_head = 0, m_tail = 0, m_drop = 0, m_pulses = 0;
  logic [7:0] m_sw = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ring rule: one slot stays empty; a full ring loses the event.
  task automatic model_event(input logic [7:0] v, input int acc_cyc);
    if (((m_head + 1) % DEPTH) == m_tail) begin
      if (m_drop < 255) m_drop++;
    end else begin
      exp_q.push_back({6'(m_head), v, 24'(acc_cyc / P)});
      m_head = (m_head + 1) % DEPTH;
      m_pulses++;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive one clean change at a negedge; acceptance comes 2 sync cycles
  // plus D stable cycles later, visible on debounced_sw one cycle after.
  task automatic do_change(input logic [7:0] v);
    int c;
    c = cyc;
    switch_in = v;
    wait_cyc(c + 2 + D);
    check("deb_hold", debounced_sw, m_sw);
    wait_cyc(c + 3 + D);
    check("deb_update", debounced_sw, v);
    model_event(v, c + 2 + D);
    m_sw = v;
    wait_cyc(c + 3 + D + 8);
  endtask

  task automatic drain(input string tag);
    logic [37:0] e, a;
    check({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      check(tag, 64'(a), 64'(e));
    end
    exp_q.delete();
    act_q.delete();
    check({tag, "_pulses"}, 64'(pulses), 64'(m_pulses));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    int saved_hdr;
    logic [7:0] v;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[HDR] = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {s2.chipselect, s2.clken, s2.write, s2.byteenable, event_pulse}, 0);
    check("rst_addr", s2.address, 0);
    check("rst_wdata", s2.writedata, 0);
    check("rst_deb", debounced_sw, 0);
    check("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    wait_cyc(4);
    check("init_hdr_writes", hdr_writes, 1);
    check("init_hdr_val", mem[HDR], 0);
    check("init_idle", s2.chipselect, 0);

    // First change 0 -> 05
    do_change(8'h05);
    drain("rec05");
    check("hdr_after_05", mem[HDR], 1);

    // Bounce: to 00, then bit0 chatter, then settle on 01
    do_change(8'h00);
    for (int i = 0; i < 48; i++) begin
      switch_in[0] = ~switch_in[0];
      repeat (2) @(negedge clk);
    end
    do_change(8'h01);
    drain("bounce");
    check("bounce_drop", drop_count, 0);

    // Second acceptance lands while the first waits for the tail read:
    // first event is overwritten (one drop), only the latest is recorded.
    c = cyc;
    switch_in = 8'hA0;
    wait_cyc(c + 3);
    switch_in = 8'hA1;
    wait_cyc(c + 6 + D);
    check("ovw_deb", debounced_sw, 8'hA1);
    m_drop++;
    model_event(8'hA1, c + 5 + D);
    m_sw = 8'hA1;
    wait_cyc(c + 6 + D + 10);
    check("ovw_drop", drop_count, m_drop);
    drain("overwrite");

    // Second acceptance lands during the record write: both kept, no drop.
    c = cyc;
    switch_in = 8'hB0;
    wait_cyc(c + 4);
    switch_in = 8'hB1;
    wait_cyc(c + 7 + D);
    check("wrrec_deb", debounced_sw, 8'hB1);
    model_event(8'hB0, c + 2 + D);
    model_event(8'hB1, c + 6 + D);
    m_sw = 8'hB1;
    wait_cyc(c + 7 + D + 12);
    check("wrrec_drop", drop_count, m_drop);
    drain("wr_rec_accept");
    check("hdr_before_abort", mem[HDR], 64'(m_head));

    // Reset asserted during the record write aborts it.
    c = cyc;
    switch_in = 8'hC3;
    wait_cyc(c + 2 + D + 4);
    check("abort_state", fsm_state, ST_WR_REC);
    check("abort_bus", {s2.chipselect, s2.write, s2.address}, {1'b1, 1'b1, RB + 12'(m_head)});
    rst_n = 1'b0;
    switch_in = 8'h00;
    #1;
    check("abort_cs_low", s2.chipselect, 0);
    repeat (2) @(negedge clk);
    saved_hdr = hdr_writes;
    rst_n = 1'b1;
    m_head = 0; m_drop = 0; m_sw = 8'h00;
    wait_cyc(4);
    check("abort_slot", mem[RB + 12'd6], 0);
    check("abort_hdr_writes", hdr_writes, saved_hdr + 1);
    check("abort_hdr_val", mem[HDR], 0);
    check("abort_drop", drop_count, 0);
    check("abort_deb", debounced_sw, 0);
    drain("abort");

    // Tail held at 0: 64 random distinct changes fill 63 slots, one drop.
    m_tail = 0;
    mem[HDR + 12'd1] = 32'h0;
    for (int i = 0; i < 64; i++) begin
      do v = 8'($urandom); while (v == m_sw);
      do_change(v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("fill_hdr", mem[HDR], 64'(m_head));
    check("fill_head63", m_head, 63);
    check("fill_drop", drop_count, m_drop);
    drain("fill");

    // Tail moves to 10 (upper bits must be ignored): next record in slot 63, head wraps.
    m_tail = 10;
    mem[HDR + 12'd1] = 32'hABCD_0000 | 32'(10);
    do v = 8'($urandom); while (v == m_sw);
    do_change(v);
    check("wrap_hdr", mem[HDR], 64'(m_head));
    check("wrap_drop", drop_count, m_drop);
    drain("wrap");

    check("bus_protocol", bus_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
